// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions: GPR geometry and the register-address type
// used by decode, hazard and MEM/WB logic.
package cpu_defs;
  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;

  typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;

  localparam gpr_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_regfile_read_port.sv
// One register-file read port: $0 forces zero, then same-cycle write
// bypass, then the stored value.
module rf_read_port
  import cpu_defs::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int BYPASS = 1,
  parameter int NREGS  = 2**ADDR_W
) (
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic                         byp_en_i,
  input  logic [ADDR_W-1:0]            byp_addr_i,
  input  logic [DATA_W-1:0]            byp_data_i,
  input  logic [NREGS-1:0][DATA_W-1:0] regs_i,
  output logic [DATA_W-1:0]            data_o
);

  always_comb begin
    data_o = regs_i[addr_i];
    if (addr_i == ADDR_W'(REG_ZERO)) begin
      data_o = '0;
    end else if ((BYPASS != 0) && byp_en_i && (addr_i == byp_addr_i)) begin
      data_o = byp_data_i;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file at the write-back end of MEM/WB: 31 stored
// GPRs ($0 has no state), three bypassed read ports and a commit counter.
module wb_regfile
  import cpu_defs::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW_i,
  input  logic [DATA_W-1:0] WriteRegData_i,
  input  logic [ADDR_W-1:0] WriteRegAddr_i,
  input  logic [ADDR_W-1:0] ReadAddr1_i,
  input  logic [ADDR_W-1:0] ReadAddr2_i,
  output logic [DATA_W-1:0] ReadData1_o,
  output logic [DATA_W-1:0] ReadData2_o,
  input  logic [ADDR_W-1:0] DbgAddr_i,
  output logic [DATA_W-1:0] DbgData_o,
  output logic [CNT_W-1:0]  WbCount_o
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0]            gpr_q [1:NREGS-1];
  logic [DATA_W-1:0]            gpr_d [1:NREGS-1];
  logic [CNT_W-1:0]             wb_count_q;
  logic [CNT_W-1:0]             wb_count_d;
  logic [NREGS-1:0][DATA_W-1:0] gpr_view;
  logic                         wr_en;
  logic                         byp_en;

  assign wr_en  = RegWriteW_i && (WriteRegAddr_i != ADDR_W'(REG_ZERO));
  // Bypass is held off during reset so every read port returns zero then.
  assign byp_en = RegWriteW_i && rst;

  always_comb begin
    gpr_d      = gpr_q;
    wb_count_d = wb_count_q;
    if (wr_en) begin
      gpr_d[WriteRegAddr_i] = WriteRegData_i;
      wb_count_d            = wb_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) gpr_q[i] <= '0;
      wb_count_q <= '0;
    end else begin
      gpr_q      <= gpr_d;
      wb_count_q <= wb_count_d;
    end
  end

  always_comb begin
    gpr_view[0] = '0;
    for (int i = 1; i < NREGS; i++) gpr_view[i] = gpr_q[i];
  end

  assign WbCount_o = wb_count_q;

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .NREGS(NREGS)) u_rd1 (
    .addr_i     (ReadAddr1_i),
    .byp_en_i   (byp_en),
    .byp_addr_i (WriteRegAddr_i),
    .byp_data_i (WriteRegData_i),
    .regs_i     (gpr_view),
    .data_o     (ReadData1_o)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .NREGS(NREGS)) u_rd2 (
    .addr_i     (ReadAddr2_i),
    .byp_en_i   (byp_en),
    .byp_addr_i (WriteRegAddr_i),
    .byp_data_i (WriteRegData_i),
    .regs_i     (gpr_view),
    .data_o     (ReadData2_o)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .NREGS(NREGS)) u_dbg (
    .addr_i     (DbgAddr_i),
    .byp_en_i   (byp_en),
    .byp_addr_i (WriteRegAddr_i),
    .byp_data_i (WriteRegData_i),
    .regs_i     (gpr_view),
    .data_o     (DbgData_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a bypassing instance with a 2-bit counter
// (to reach wrap) and a non-bypassing instance share one stimulus stream.
module tb_wb_regfile;
  import cpu_defs::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic [31:0] wd;
  logic [4:0]  wa, ra1, ra2, rad;

  logic [31:0] b_rd1, b_rd2, b_dbg;
  logic [1:0]  b_cnt;
  logic [31:0] n_rd1, n_rd2, n_dbg;
  logic [31:0] n_cnt;

  int n_cmp;
  int n_mis;

  wb_regfile #(.BYPASS(1), .CNT_W(2)) u_byp (
    .clk(clk), .rst(rst), .RegWriteW_i(we), .WriteRegData_i(wd), .WriteRegAddr_i(wa),
    .ReadAddr1_i(ra1), .ReadAddr2_i(ra2), .ReadData1_o(b_rd1), .ReadData2_o(b_rd2),
    .DbgAddr_i(rad), .DbgData_o(b_dbg), .WbCount_o(b_cnt)
  );

  wb_regfile #(.BYPASS(0), .CNT_W(32)) u_nob (
    .clk(clk), .rst(rst), .RegWriteW_i(we), .WriteRegData_i(wd), .WriteRegAddr_i(wa),
    .ReadAddr1_i(ra1), .ReadAddr2_i(ra2), .ReadData1_o(n_rd1), .ReadData2_o(n_rd2),
    .DbgAddr_i(rad), .DbgData_o(n_dbg), .WbCount_o(n_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; rad = rd;
  endtask

  // Present one transaction at the negedge and let it commit at the next posedge.
  task automatic commit(input logic w, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(w, a, d, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1 drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'hCAFE0001, 5'd5, 5'd5, 5'd5);

    // T1: reset held, a write is presented; no bypass and nothing committed
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd1", b_rd1, 32'h0);
    chk("rst_rd2", b_rd2, 32'h0);
    chk("rst_dbg", b_dbg, 32'h0);
    chk("rst_cnt", n_cnt, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd1, 5'd31);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_r5", b_rd1, 32'h0);
    chk("post_rst_r31", b_dbg, 32'h0);
    chk("post_rst_cnt", {30'h0, b_cnt}, 32'h0);

    // T2: write R5 then read it back
    commit(1'b1, 5'd5, 32'hDEADBEEF);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5);
    #1;
    chk("t2_rd1", b_rd1, 32'hDEADBEEF);
    chk("t2_dbg", n_dbg, 32'hDEADBEEF);
    chk("t2_cnt", n_cnt, 32'd1);
    chk("t2_cnt_small", {30'h0, b_cnt}, 32'd1);

    // T3: write to $0 is dropped and not counted, and never bypassed
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    #1;
    chk("t3_byp_r0", b_rd1, 32'h0);
    @(posedge clk);
    #1 drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("t3_rd1", b_rd1, 32'h0);
    chk("t3_rd2", b_rd2, 32'h0);
    chk("t3_dbg", b_dbg, 32'h0);
    chk("t3_cnt", n_cnt, 32'd1);

    // T4: same-cycle write and reads of R7, with and without bypass
    commit(1'b1, 5'd7, 32'h11111111);
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 5'd7);
    #1;
    chk("t4_byp_rd1", b_rd1, 32'h12345678);
    chk("t4_byp_rd2", b_rd2, 32'h12345678);
    chk("t4_byp_dbg", b_dbg, 32'h12345678);
    chk("t4_nob_rd1", n_rd1, 32'h11111111);
    chk("t4_nob_rd2", n_rd2, 32'h11111111);
    chk("t4_nob_dbg", n_dbg, 32'h11111111);
    @(posedge clk);
    #1 drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd5, 5'd0);
    #1;
    chk("t4_nob_after", n_rd1, 32'h12345678);
    chk("t4_r5_kept", n_rd2, 32'hDEADBEEF);
    chk("t4_cnt", n_cnt, 32'd3);

    // T5: bubble on R9 leaves it and the counter alone; 2-bit counter wraps at 4
    commit(1'b1, 5'd9, 32'h00000099);
    #1;
    chk("t5_wrap", {30'h0, b_cnt}, 32'd0);
    @(negedge clk);
    drive(1'b0, 5'd9, 32'hAAAA5555, 5'd9, 5'd7, 5'd9);
    #1;
    chk("t5_bubble_nobyp", b_rd1, 32'h00000099);
    @(posedge clk);
    #1;
    chk("t5_r9_kept", b_dbg, 32'h00000099);
    chk("t5_r7", b_rd2, 32'h12345678);
    chk("t5_cnt", n_cnt, 32'd4);
    chk("t5_cnt_small", {30'h0, b_cnt}, 32'd0);

    // T6: asynchronous reset between edges, with a write pending at the next edge
    commit(1'b1, 5'd3, 32'h00000001);
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 5'd0);
    #1;
    chk("t6_r3_set", b_rd1, 32'h00000001);
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h00000BAD, 5'd3, 5'd5, 5'd3);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_r3", n_rd1, 32'h0);
    chk("t6_async_r5", b_rd2, 32'h0);
    chk("t6_async_byp", b_dbg, 32'h0);
    chk("t6_async_cnt", n_cnt, 32'h0);
    @(posedge clk);
    #1 drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd9, 5'd3);
    #1 rst = 1'b1;
    #1;
    chk("t6_discard_r3", b_rd1, 32'h0);
    chk("t6_discard_r9", n_rd2, 32'h0);
    chk("t6_discard_cnt", n_cnt, 32'h0);
    chk("t6_discard_cnt_small", {30'h0, b_cnt}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule
